// File: rtl/game_pkg.sv
// Shared game definitions: tracker FSM states, screen geometry and
// 60 MHz cycle constants used by the trajectory generator, the tracker
// and the display overlay.
package game_pkg;

  // Coordinate and timer widths shared by the trajectory path.
  localparam int unsigned COORD_W = 12;
  localparam int unsigned TIMER_W = 28;
  localparam int unsigned SCORE_W = 8;

  // Screen geometry; the ground row coincides with the bottom of the screen.
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned GROUND_Y = 768;

  // Cycle counts at 60 MHz.
  localparam int unsigned CYC_PER_MS = 60_000;

  // Largest value the saturating score can hold.
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Lifecycle of one throw as seen by the tracker.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    FLIGHT = 2'd2,
    HOLD   = 2'd3
  } tracker_state_t;

  // Converts a duration in milliseconds to 60 MHz clock cycles.
  function automatic int unsigned ms_to_cyc(input int unsigned ms);
    return ms * CYC_PER_MS;
  endfunction

endpackage

// File: rtl/target_cmp.sv
// Combinational target-box test: the point is inside the target when x lies
// within [X_MIN, X_MAX] and y is at or below the box top (y >= Y_MIN).
// Shared with the display overlay so both agree on what counts as a hit.
module target_cmp #(
  parameter int unsigned X_MIN = 824,
  parameter int unsigned X_MAX = 904,
  parameter int unsigned Y_MIN = 640
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_in_target
);

  localparam logic [11:0] X_MIN_C = 12'(X_MIN);
  localparam logic [11:0] X_MAX_C = 12'(X_MAX);
  localparam logic [11:0] Y_MIN_C = 12'(Y_MIN);

  logic w_x_in_range;
  logic w_y_below_top;

  assign w_x_in_range  = (i_x >= X_MIN_C) && (i_x <= X_MAX_C);
  assign w_y_below_top = (i_y >= Y_MIN_C);
  assign o_in_target   = w_x_in_range && w_y_below_top;

endmodule

// File: rtl/projectile_tracker.sv
// Downstream stage of the vertical-trajectory generator. Buffers the raw
// projectile coordinates, classifies each throw as hit or miss, pulses
// end_throw to return the generator to its wait state, and keeps a
// saturating hit score.
module projectile_tracker #(
  parameter int unsigned GROUND_Y     = game_pkg::GROUND_Y,
  parameter int unsigned ARM_Y        = 700,
  parameter int unsigned TARGET_X_MIN = 824,
  parameter int unsigned TARGET_X_MAX = 904,
  parameter int unsigned TARGET_Y_MIN = 640,
  parameter int unsigned TIMEOUT_CYC  = 180_000_000,
  parameter int unsigned HOLD_CYC     = 15_000_000
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        throw_start,
  input  logic [11:0] xpos_prebuff,
  input  logic [11:0] ypos_prebuff,
  input  logic        score_clr,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        end_throw,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score
);

  import game_pkg::*;

  localparam logic [11:0]        GROUND_Y_C    = 12'(GROUND_Y);
  localparam logic [11:0]        ARM_Y_C       = 12'(ARM_Y);
  localparam logic [TIMER_W-1:0] TIMEOUT_LIM_C = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LIM_C    = TIMER_W'(HOLD_CYC - 1);

  // State and datapath registers
  tracker_state_t     r_state;
  logic [11:0]        r_xpos;
  logic [11:0]        r_ypos;
  logic [TIMER_W-1:0] r_timer;
  logic               r_end_throw;
  logic               r_hit;
  logic               r_miss;
  logic [7:0]         r_score;

  // Combinational decisions
  tracker_state_t     w_state_next;
  logic               w_in_target;
  logic               w_armed;
  logic               w_grounded;
  logic               w_timeout;
  logic               w_hold_done;
  logic               w_finish_hit;
  logic               w_finish_miss;
  logic               w_finish;
  logic [TIMER_W-1:0] w_timer_next;
  logic               w_hit_next;
  logic               w_miss_next;
  logic [7:0]         w_score_next;

  // Target box test on the registered coordinates.
  target_cmp #(
    .X_MIN (TARGET_X_MIN),
    .X_MAX (TARGET_X_MAX),
    .Y_MIN (TARGET_Y_MIN)
  ) u_target_cmp (
    .i_x         (r_xpos),
    .i_y         (r_ypos),
    .o_in_target (w_in_target)
  );

  // Classification always looks at the buffered coordinates, never the raw
  // inputs, so the decision matches what the display shows.
  assign w_armed     = (r_ypos < ARM_Y_C);
  assign w_grounded  = (r_ypos >= GROUND_Y_C);
  assign w_timeout   = (r_timer >= TIMEOUT_LIM_C);
  assign w_hold_done = (r_timer >= HOLD_LIM_C);

  // Coordinate buffer: one cycle of latency in every state.
  always_ff @(posedge clk60MHz) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      r_xpos <= '0;
      r_ypos <= GROUND_Y_C;
    end else begin
      r_xpos <= xpos_prebuff;
      r_ypos <= ypos_prebuff;
    end
  end

  // State register; reset aborts any throw in progress without a pulse.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Arming wins over the timeout in ARMING; in FLIGHT the
  // target test wins over ground, which wins over timeout (all three finish).
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // and infers a latch.
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (throw_start) w_state_next = ARMING;
      end
      ARMING: begin
        if (w_armed)        w_state_next = FLIGHT;
        else if (w_timeout) w_state_next = HOLD;
      end
      FLIGHT: begin
        if (w_in_target || w_grounded || w_timeout) w_state_next = HOLD;
      end
      HOLD: begin
        if (w_hold_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: finish classification, timer, hit/miss and score updates.
  always_comb begin
    w_finish_hit  = 1'b0;
    w_finish_miss = 1'b0;
    case (r_state)
      ARMING: begin
        w_finish_miss = !w_armed && w_timeout;
      end
      FLIGHT: begin
        w_finish_hit  = w_in_target;
        w_finish_miss = !w_in_target && (w_grounded || w_timeout);
      end
      default: begin
        w_finish_hit  = 1'b0;
        w_finish_miss = 1'b0;
      end
    endcase
    w_finish = w_finish_hit || w_finish_miss;

    // Timer keeps running from ARMING into FLIGHT so the timeout covers the
    // whole throw; it restarts at finish so HOLD measures from zero.
    w_timer_next = r_timer + TIMER_W'(1);
    if (r_state == IDLE || w_finish || (r_state == HOLD && w_hold_done)) begin
      w_timer_next = '0;
    end

    w_hit_next  = r_hit;
    w_miss_next = r_miss;
    if (w_finish) begin
      w_hit_next  = w_finish_hit;
      w_miss_next = w_finish_miss;
    end else if (r_state == HOLD && w_hold_done) begin
      w_hit_next  = 1'b0;
      w_miss_next = 1'b0;
    end

    // Clear has priority over a coincident hit increment.
    w_score_next = r_score;
    if (score_clr) begin
      w_score_next = '0;
    end else if (w_finish_hit && (r_score != SCORE_MAX)) begin
      w_score_next = r_score + 8'd1;
    end
  end

  // Registered outputs and timer; end_throw rises on the same edge as the
  // move into HOLD and lasts exactly one cycle.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_timer     <= '0;
      r_end_throw <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_score     <= '0;
    end else begin
      r_timer     <= w_timer_next;
      r_end_throw <= w_finish;
      r_hit       <= w_hit_next;
      r_miss      <= w_miss_next;
      r_score     <= w_score_next;
    end
  end

  assign xpos      = r_xpos;
  assign ypos      = r_ypos;
  assign end_throw = r_end_throw;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign score     = r_score;

endmodule

// File: tb/tb_projectile_tracker.sv
// Directed bench for projectile_tracker with shortened timeout/hold windows.
`timescale 1ns/1ps
module tb_projectile_tracker;
  import game_pkg::*;

  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int unsigned HOLD_CYC    = 100;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic        throw_start;
  logic [11:0] xpos_prebuff;
  logic [11:0] ypos_prebuff;
  logic        score_clr;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        end_throw;
  logic        hit;
  logic        miss;
  logic [7:0]  score;

  int n_total = 0;
  int n_pass  = 0;

  projectile_tracker #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .HOLD_CYC    (HOLD_CYC)
  ) dut (
    .clk60MHz     (clk60MHz),
    .rst          (rst),
    .throw_start  (throw_start),
    .xpos_prebuff (xpos_prebuff),
    .ypos_prebuff (ypos_prebuff),
    .score_clr    (score_clr),
    .xpos         (xpos),
    .ypos         (ypos),
    .end_throw    (end_throw),
    .hit          (hit),
    .miss         (miss),
    .score        (score)
  );

  always #8 clk60MHz = ~clk60MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  // Start a throw at column x; returns with the DUT in FLIGHT and ypos=300.
  task automatic launch(input logic [11:0] x);
    xpos_prebuff = x;
    ypos_prebuff = 12'd454;
    throw_start  = 1'b1;
    step();
    throw_start  = 1'b0;
    ypos_prebuff = 12'd300;
    step();
  endtask

  // Complete one hit and its hold window, returning in IDLE.
  task automatic do_hit();
    launch(12'd850);
    ypos_prebuff = 12'd650;
    step();
    step();
    repeat (HOLD_CYC) step();
  endtask

  // Count edges until end_throw is seen, bounded.
  task automatic wait_end(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (end_throw !== 1'b1 && n < 200);
  endtask

  initial begin
    int n;
    int bad;

    // ---- 1: reset and idle ----
    rst = 1'b1; throw_start = 1'b0; score_clr = 1'b0;
    xpos_prebuff = 12'd100; ypos_prebuff = 12'd768;
    step();
    check("rst_xpos", 32'(xpos), 32'd0);
    check("rst_ypos", 32'(ypos), 32'd768);
    check("rst_score", 32'(score), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    step();
    check("buf_xpos", 32'(xpos), 32'd100);
    check("buf_ypos", 32'(ypos), 32'd768);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (end_throw || hit || miss || dut.r_state != IDLE) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    xpos_prebuff = 12'd123;
    #1;
    check("buf_latency_before", 32'(xpos), 32'd100);
    step();
    check("buf_latency_after", 32'(xpos), 32'd123);

    // ---- 2: ground miss ----
    launch(12'd200);
    check("t2_state_flight", 32'(dut.r_state), 32'(FLIGHT));
    ypos_prebuff = 12'd600;
    step();
    ypos_prebuff = 12'd770;
    step();
    check("t2_ypos770", 32'(ypos), 32'd770);
    check("t2_no_end_yet", 32'(end_throw), 32'd0);
    step();
    check("t2_end", 32'(end_throw), 32'd1);
    check("t2_miss", 32'(miss), 32'd1);
    check("t2_hit", 32'(hit), 32'd0);
    bad = 0;
    for (int i = 1; i < int'(HOLD_CYC); i++) begin
      step();
      if (end_throw !== 1'b0 || miss !== 1'b1 || hit !== 1'b0) bad++;
    end
    check("t2_hold_stable", 32'(bad), 32'd0);
    step();
    check("t2_miss_cleared", 32'(miss), 32'd0);
    check("t2_idle", 32'(dut.r_state), 32'(IDLE));
    check("t2_score", 32'(score), 32'd0);

    // ---- 3: target hit ----
    launch(12'd850);
    ypos_prebuff = 12'd650;
    step();
    check("t3_no_end_yet", 32'(end_throw), 32'd0);
    step();
    check("t3_end", 32'(end_throw), 32'd1);
    check("t3_hit", 32'(hit), 32'd1);
    check("t3_miss", 32'(miss), 32'd0);
    check("t3_score", 32'(score), 32'd1);
    repeat (HOLD_CYC - 1) step();
    check("t3_hit_held", 32'(hit), 32'd1);
    check("t3_end_low", 32'(end_throw), 32'd0);
    step();
    check("t3_hit_cleared", 32'(hit), 32'd0);
    check("t3_idle", 32'(dut.r_state), 32'(IDLE));

    // ---- 4: hit and ground together ----
    launch(12'd850);
    ypos_prebuff = 12'd770;
    step();
    step();
    check("t4_end", 32'(end_throw), 32'd1);
    check("t4_hit", 32'(hit), 32'd1);
    check("t4_miss", 32'(miss), 32'd0);
    check("t4_score", 32'(score), 32'd2);
    repeat (HOLD_CYC) step();
    check("t4_idle", 32'(dut.r_state), 32'(IDLE));

    // ---- 5: timeout with y stuck at ground level ----
    xpos_prebuff = 12'd200;
    ypos_prebuff = 12'd768;
    step();
    throw_start = 1'b1;
    step();
    throw_start = 1'b0;
    check("t5_arming", 32'(dut.r_state), 32'(ARMING));
    wait_end(n);
    check("t5_timeout_cycles", 32'(n), 32'd50);
    check("t5_end", 32'(end_throw), 32'd1);
    check("t5_miss", 32'(miss), 32'd1);
    check("t5_hit", 32'(hit), 32'd0);
    check("t5_score", 32'(score), 32'd2);
    step();
    check("t5_end_single", 32'(end_throw), 32'd0);
    repeat (HOLD_CYC - 1) step();
    check("t5_idle", 32'(dut.r_state), 32'(IDLE));

    // ---- 6: saturation, clear priority, reset mid-flight ----
    repeat (253) do_hit();
    check("t6_score_255", 32'(score), 32'd255);
    launch(12'd850);
    ypos_prebuff = 12'd650;
    step();
    step();
    check("t6_sat_hit", 32'(hit), 32'd1);
    check("t6_sat_score", 32'(score), 32'd255);
    repeat (HOLD_CYC) step();
    launch(12'd850);
    ypos_prebuff = 12'd650;
    step();
    score_clr = 1'b1;
    step();
    score_clr = 1'b0;
    check("t6_clr_hit", 32'(hit), 32'd1);
    check("t6_clr_score", 32'(score), 32'd0);
    repeat (HOLD_CYC) step();
    do_hit();
    check("t6_score_after_clr", 32'(score), 32'd1);
    launch(12'd200);
    check("t6_in_flight", 32'(dut.r_state), 32'(FLIGHT));
    rst = 1'b1;
    step();
    check("t6_rst_xpos", 32'(xpos), 32'd0);
    check("t6_rst_ypos", 32'(ypos), 32'd768);
    check("t6_rst_end", 32'(end_throw), 32'd0);
    check("t6_rst_hit", 32'(hit), 32'd0);
    check("t6_rst_miss", 32'(miss), 32'd0);
    check("t6_rst_score", 32'(score), 32'd0);
    check("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    ypos_prebuff = 12'd800;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (end_throw !== 1'b0) bad++;
    end
    check("t6_no_end_after_rst", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
